crp16_mmio_bridge: RTL and testbench
====================================

Name: crp16_mmio_bridge

Overview:
- Sits on the data port (port B) between the CRP16 datapath and the dual-port RAM.
- Splits the 16-bit word address space into two regions:
  - RAM region: address below MMIO_BASE, passed through to RAM.
  - MMIO page: a small bank of memory-mapped I/O registers, covering a seven-segment display, LEDs, switches and a prescaled timer with compare.
- Port A (instruction fetch) does not pass through this block.

Parameters:
- MMIO_BASE, 16'hFF00: first word address of the MMIO page. Addresses at or above it are MMIO; the register offset is address_b[3:0], with address_b[7:4] ignored.
- TIMER_DIV, 16: number of clock cycles per timer tick, range 1..65535.
- LED_WIDTH, 10: width of the LED output register.

Ports:
- clock  in  1  system clock (posedge); also drives mem_clock.
- resetn  in  1  asynchronous active-low reset.
- address_b  in  16  data address from datapath.
- data_b  in  16  store data from datapath.
- wren_b  in  1  store strobe from datapath.
- q_b  out  16  read data to datapath.
- ram_address_b  out  16  address to RAM port B (equals address_b).
- ram_data_b  out  16  store data to RAM (equals data_b).
- ram_wren_b  out  1  RAM write enable; asserted only for RAM-region stores.
- ram_q_b  in  16  RAM port B read data (1-cycle latency).
- sw  in  LED_WIDTH  raw board switches (asynchronous).
- ledr  out  LED_WIDTH  LED register.
- hex0, hex1, hex2, hex3  out  7 each  active-low seven-segment for HEX nibbles 0..3.

Behaviour:
- Address decode:
  - mmio_sel = (address_b >= MMIO_BASE), combinational.
  - ram_wren_b = wren_b & ~mmio_sel.
- Read path:
  - At each posedge, register sel_q <= mmio_sel and mmio_rdata_q <= MMIO read mux(offset).
  - q_b = sel_q ? mmio_rdata_q : ram_q_b.
  - This gives the same 1-cycle latency as RAM.
  - q_b holds its value while address_b is unchanged, as the datapath samples it in both EM and WB.
- Register map (offset: name, access):
  - 0x0 HEX, RW, 16 bits. Nibble k drives hexk through a hex decoder.
  - 0x1 LEDR, RW, LED_WIDTH bits. Reads zero-extended.
  - 0x2 SW, RO. 2-flop synchronised sw, zero-extended. Writes ignored.
  - 0x3 TCNT, RW. Timer count.
  - 0x4 TCMP, RW. Compare value.
  - 0x5 TSTAT, RW:
    - bit0 MATCH: sticky; write-1-to-clear.
    - bit1 EN: timer enable.
    - bit2 IRQEN: only with the optional feature, otherwise reads 0.
    - Other bits read 0.
  - 0x6..0xF: read 0, writes ignored.
- Writes: the selected register updates at the posedge where wren_b & mmio_sel is high. RAM is untouched.
- Timer:
  - A prescaler counts 0..TIMER_DIV-1 while EN=1 and produces a one-cycle tick on reaching TIMER_DIV-1, then returns to 0.
  - The prescaler is held at 0 while EN=0.
  - On tick: TCNT <= TCNT+1, wrapping 16'hFFFF -> 0.
  - If the post-increment value equals TCMP, MATCH is set.
- Simultaneous events:
  - CPU write to TCNT in a tick cycle: the written value wins and no match is evaluated that cycle.
  - W1C of MATCH in the same cycle as a match set: the set wins (MATCH=1).
  - Writing EN=0 clears the prescaler on the next edge.
  - Writing TCMP has no effect until the next tick.
- Reset (resetn=0, asynchronous), all values zero:
  - HEX=0, so hex0..3 show "0" (7'b1000000).
  - LEDR=0, TCNT=0, TCMP=0, TSTAT=0, prescaler=0.
  - SW synchronisers=0, sel_q=0, mmio_rdata_q=0, so q_b follows ram_q_b.
  - Reset mid-operation discards any in-flight read; the first read after release returns valid data one cycle later.
- Combinational pass-throughs (ram_address_b, ram_data_b) are unaffected by reset.

Optional Feature:
- Macro: CRP16_MMIO_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - irq = MATCH & IRQEN, registered, with reset value 0.
  - TSTAT bit2 is RW IRQEN.
- When undefined:
  - No irq port.
  - TSTAT bit2 reads 0 and writes to it are ignored.

Test Plan:
- RAM passthrough:
  - Store 16'h1234 to 16'h0040 -> ram_wren_b=1.
  - Load 16'h0040 -> q_b=16'h1234 one cycle later.
  - Store to 16'hFF01 -> ram_wren_b=0.
- HEX/LEDR:
  - Write 16'hBEEF to FF00 -> hex3..0 = b, E, E, F patterns; read-back FF00 = 16'hBEEF.
  - Write 16'hFFFF to FF01 -> ledr=10'h3FF; read-back = 16'h03FF.
- Switches: sw=10'h2A5 -> read FF02 returns 16'h02A5 no earlier than 2 cycles after sw changes; unused offset FF0A reads 0.
- Timer, TIMER_DIV=4:
  - Setup: TCMP=3, then TSTAT=2 -> TCNT reaches 3 after 12 cycles and MATCH=1.
  - Write 16'h1 to TSTAT (W1C plus EN=0): MATCH clears and EN is also cleared.
  - Wrap case: TCNT=16'hFFFF -> 0 on the next tick.
- Collisions:
  - TCNT write coincident with a tick -> the written value is held.
  - MATCH W1C coincident with a match -> MATCH stays 1.
- Reset: assert resetn=0 mid-count asynchronously (between edges) -> all registers, q_b mux and irq go to 0 immediately; hex0 = 7'b1000000.

Source files
------------

// File: rtl/crp16_mmio_bridge.sv
// CRP16 data-port bridge: splits port B into RAM pass-through and an MMIO page
// (HEX, LEDR, SW, prescaled timer). Define CRP16_MMIO_IRQ_EN for TSTAT.IRQEN and irq.

module crp16_hex7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module crp16_mmio_bridge #(
  parameter logic [15:0] MMIO_BASE = 16'hFF00,
  parameter int          TIMER_DIV = 16,
  parameter int          LED_WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [15:0]          address_b,
  input  logic [15:0]          data_b,
  input  logic                 wren_b,
  output logic [15:0]          q_b,
  output logic [15:0]          ram_address_b,
  output logic [15:0]          ram_data_b,
  output logic                 ram_wren_b,
  input  logic [15:0]          ram_q_b,
  input  logic [LED_WIDTH-1:0] sw,
  output logic [LED_WIDTH-1:0] ledr,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic [6:0]           hex3
`ifdef CRP16_MMIO_IRQ_EN
  ,
  output logic                 irq
`endif
);
  localparam logic [15:0] DIV_LAST = 16'(TIMER_DIV - 1);

  logic                 mmio_sel, mmio_wr, tick, match_set;
  logic [3:0]           offset;
  logic [15:0]          wr, rdata, led_ext, sw_ext, tcnt_inc;
  logic [15:0]          hex_r, tcnt, tcmp, presc, mmio_rdata_q;
  logic [LED_WIDTH-1:0] sw_s1, sw_s2;
  logic                 match, en, sel_q;
  logic [3:0][6:0]      segs;
`ifdef CRP16_MMIO_IRQ_EN
  logic                 irqen;
`endif

  assign mmio_sel      = (address_b >= MMIO_BASE);
  assign mmio_wr       = wren_b & mmio_sel;
  assign offset        = address_b[3:0];
  assign ram_address_b = address_b;
  assign ram_data_b    = data_b;
  assign ram_wren_b    = wren_b & ~mmio_sel;
  assign q_b           = sel_q ? mmio_rdata_q : ram_q_b;

  always_comb begin
    wr = '0;
    if (mmio_wr) wr[offset] = 1'b1;
  end

  always_comb begin
    led_ext = '0;
    sw_ext  = '0;
    led_ext[LED_WIDTH-1:0] = ledr;
    sw_ext[LED_WIDTH-1:0]  = sw_s2;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      4'h0: rdata = hex_r;
      4'h1: rdata = led_ext;
      4'h2: rdata = sw_ext;
      4'h3: rdata = tcnt;
      4'h4: rdata = tcmp;
      4'h5: begin
        rdata[0] = match;
        rdata[1] = en;
`ifdef CRP16_MMIO_IRQ_EN
        rdata[2] = irqen;
`endif
      end
      default: rdata = '0;
    endcase
  end

  // A CPU write to TCNT in a tick cycle overrides the increment and suppresses the match.
  assign tick      = en && (presc == DIV_LAST);
  assign tcnt_inc  = tcnt + 16'd1;
  assign match_set = tick && !wr[3] && (tcnt_inc == tcmp);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
      tcnt  <= '0;
      tcmp  <= '0;
      match <= 1'b0;
      en    <= 1'b0;
    end else begin
      presc <= (!en || tick) ? 16'd0 : presc + 16'd1;
      if (wr[3])     tcnt <= data_b;
      else if (tick) tcnt <= tcnt_inc;
      if (wr[4]) tcmp <= data_b;
      if (wr[5]) en <= data_b[1];
      // Set has priority over write-1-to-clear.
      match <= match_set | (match & ~(wr[5] & data_b[0]));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hex_r        <= '0;
      ledr         <= '0;
      sw_s1        <= '0;
      sw_s2        <= '0;
      sel_q        <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      if (wr[0]) hex_r <= data_b;
      if (wr[1]) ledr  <= data_b[LED_WIDTH-1:0];
      sw_s1        <= sw;
      sw_s2        <= sw_s1;
      sel_q        <= mmio_sel;
      mmio_rdata_q <= rdata;
    end
  end

`ifdef CRP16_MMIO_IRQ_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irqen <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr[5]) irqen <= data_b[2];
      irq <= match & irqen;
    end
  end
`endif

  for (genvar k = 0; k < 4; k++) begin : g_hex
    crp16_hex7 u_hex (.nib(hex_r[4*k +: 4]), .seg(segs[k]));
  end

  assign hex0 = segs[0];
  assign hex1 = segs[1];
  assign hex2 = segs[2];
  assign hex3 = segs[3];
endmodule

// File: tb/tb_crp16_mmio_bridge.sv
// Bench for crp16_mmio_bridge: directed plan plus random traffic against a register-level model.
`timescale 1ns/1ps

module tb_crp16_mmio_bridge;
  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [15:0] addr = '0, din = '0;
  logic        wr = 1'b0;
  logic [15:0] q_b, ram_address_b, ram_data_b;
  logic        ram_wren_b;
  logic [15:0] ram_q_b = '0;
  logic [9:0]  sw_in = '0, ledr;
  logic [6:0]  hex0, hex1, hex2, hex3;
`ifdef CRP16_MMIO_IRQ_EN
  logic        irq;
`endif

  int n_chk = 0, n_err = 0;
  bit chk_on = 0;

  crp16_mmio_bridge #(.MMIO_BASE(16'hFF00), .TIMER_DIV(DIV), .LED_WIDTH(10)) dut (
    .clock(clock), .resetn(resetn), .address_b(addr), .data_b(din), .wren_b(wr),
    .q_b(q_b), .ram_address_b(ram_address_b), .ram_data_b(ram_data_b),
    .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b), .sw(sw_in), .ledr(ledr),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
`ifdef CRP16_MMIO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100;
      4'h3: return 7'b0110000; 4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000; 4'h8: return 7'b0000000;
      4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Environment RAM driven by what the DUT presents on port B.
  logic [15:0] ram_mem [int];
  initial forever begin
    logic [15:0] rd;
    @(posedge clock);
    rd = ram_mem.exists(int'(ram_address_b)) ? ram_mem[int'(ram_address_b)] : 16'h0;
    if (ram_wren_b === 1'b1) ram_mem[int'(ram_address_b)] = ram_data_b;
    ram_q_b = rd;
  end

  // Reference model: RAM content as the spec says it must evolve.
  logic [15:0] m_mem [int];
  logic [15:0] m_ramq = '0;
  initial forever begin
    @(posedge clock);
    m_ramq = m_mem.exists(int'(addr)) ? m_mem[int'(addr)] : 16'h0;
    if (wr && addr < 16'hFF00) m_mem[int'(addr)] = din;
  end

  // Reference model: MMIO registers.
  logic [15:0] m_hex, m_tcnt, m_tcmp, m_mrd;
  logic [9:0]  m_led, m_sw1, m_sw2;
  logic        m_match, m_en, m_irqen, m_irq, m_sel;
  int          m_presc;

  function automatic logic [15:0] mreg(input logic [3:0] off);
    case (off)
      4'h0: return m_hex;
      4'h1: return {6'b0, m_led};
      4'h2: return {6'b0, m_sw2};
      4'h3: return m_tcnt;
      4'h4: return m_tcmp;
      4'h5: return {13'b0, m_irqen, m_en, m_match};
      default: return 16'h0;
    endcase
  endfunction

  initial forever begin
    bit sel, w, tick, setm;
    logic [3:0] off;
    @(posedge clock or negedge resetn);
    if (!resetn) begin
      m_hex = 0; m_tcnt = 0; m_tcmp = 0; m_mrd = 0; m_led = 0; m_sw1 = 0; m_sw2 = 0;
      m_match = 0; m_en = 0; m_irqen = 0; m_irq = 0; m_sel = 0; m_presc = 0;
    end else begin
      sel = (addr >= 16'hFF00);
      w = wr && sel;
      off = addr[3:0];
      m_mrd = mreg(off);
      m_sel = sel;
      m_irq = m_match & m_irqen;
      m_sw2 = m_sw1;
      m_sw1 = sw_in;
      tick = m_en && (m_presc == DIV - 1);
      m_presc = (m_en && !tick) ? m_presc + 1 : 0;
      setm = 0;
      if (tick) begin
        m_tcnt = m_tcnt + 16'd1;
        setm = (m_tcnt == m_tcmp);
      end
      if (w && off == 4'h3) begin
        m_tcnt = din;
        setm = 0;
      end
      if (w && off == 4'h5 && din[0]) m_match = 0;
      if (setm) m_match = 1;
      if (w && off == 4'h0) m_hex = din;
      if (w && off == 4'h1) m_led = din[9:0];
      if (w && off == 4'h4) m_tcmp = din;
      if (w && off == 4'h5) begin
        m_en = din[1];
`ifdef CRP16_MMIO_IRQ_EN
        m_irqen = din[2];
`endif
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clock);
    if (chk_on) begin
      chk("q_b", q_b, m_sel ? m_mrd : m_ramq);
      chk("ram_wren_b", ram_wren_b, wr && (addr < 16'hFF00));
      chk("ram_pass", {ram_address_b, ram_data_b}, {addr, din});
      chk("ledr", ledr, m_led);
      chk("hex", {hex3, hex2, hex1, hex0},
          {seg7(m_hex[15:12]), seg7(m_hex[11:8]), seg7(m_hex[7:4]), seg7(m_hex[3:0])});
`ifdef CRP16_MMIO_IRQ_EN
      chk("irq", irq, m_irq);
`endif
    end
  end

  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
    addr = a; din = d; wr = w;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(16'h0000, 16'h0, 1'b0);
  endtask

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    chk_on = 1;
    chk("rst_hex0", hex0, 7'b1000000);
    chk("rst_ledr", ledr, 10'h0);
    chk("rst_q", q_b, 16'h0);

    // RAM pass-through
    addr = 16'h0040; din = 16'h1234; wr = 1'b1;
    #1 chk("ram_store_wren", ram_wren_b, 1'b1);
    @(posedge clock); #1;
    cyc(16'h0040, 16'h0, 1'b0);
    chk("ram_load", q_b, 16'h1234);
    addr = 16'hFF01; din = 16'h0; wr = 1'b1;
    #1 chk("mmio_store_wren", ram_wren_b, 1'b0);
    @(posedge clock); #1;

    // HEX and LEDR
    cyc(16'hFF00, 16'hBEEF, 1'b1);
    chk("hex_beef", {hex3, hex2, hex1, hex0}, {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});
    cyc(16'hFF00, 16'h0, 1'b0);
    chk("hex_rd", q_b, 16'hBEEF);
    cyc(16'hFF01, 16'hFFFF, 1'b1);
    chk("ledr_wr", ledr, 10'h3FF);
    cyc(16'hFF01, 16'h0, 1'b0);
    chk("ledr_rd", q_b, 16'h03FF);

    // Switches through the synchroniser
    sw_in = 10'h2A5;
    cyc(16'hFF02, 16'h0, 1'b0);
    chk("sw_early", q_b, 16'h0);
    cyc(16'hFF02, 16'h0, 1'b0);
    cyc(16'hFF02, 16'h0, 1'b0);
    chk("sw_rd", q_b, 16'h02A5);
    cyc(16'hFF52, 16'h0, 1'b0);
    chk("sw_alias", q_b, 16'h02A5);
    cyc(16'hFF0A, 16'h0, 1'b0);
    chk("unused_rd", q_b, 16'h0);

    // Timer: compare 3, enable, 12 cycles to match
    cyc(16'hFF04, 16'd3, 1'b1);
    cyc(16'hFF05, 16'd2, 1'b1);
    idle(12);
    cyc(16'hFF03, 16'h0, 1'b0);
    chk("tcnt_3", q_b, 16'd3);
    cyc(16'hFF05, 16'h0, 1'b0);
    chk("tstat_match", q_b, 16'd3);
    cyc(16'hFF05, 16'd1, 1'b1);
    cyc(16'hFF05, 16'h0, 1'b0);
    chk("tstat_w1c", q_b, 16'd0);

    // Wrap and collisions
    cyc(16'hFF03, 16'hFFFF, 1'b1);
    cyc(16'hFF05, 16'd2, 1'b1);
    idle(4);
    cyc(16'hFF03, 16'h0, 1'b0);
    chk("tcnt_wrap", q_b, 16'h0);
    idle(2);
    cyc(16'hFF03, 16'h0100, 1'b1);
    cyc(16'hFF03, 16'h0, 1'b0);
    chk("tcnt_wr_wins", q_b, 16'h0100);
    cyc(16'hFF04, 16'h0102, 1'b1);
    idle(5);
    cyc(16'hFF05, 16'd3, 1'b1);
    cyc(16'hFF05, 16'h0, 1'b0);
    chk("match_set_wins", q_b, 16'd3);

    // Asynchronous reset between edges
    cyc(16'hFF00, 16'h0, 1'b0);
    #3 resetn = 1'b0;
    #1;
    chk("arst_q", q_b, 16'h0);
    chk("arst_hex0", hex0, 7'b1000000);
    chk("arst_ledr", ledr, 10'h0);
    @(posedge clock); #1 resetn = 1'b1;
    cyc(16'hFF03, 16'h0, 1'b0);
    chk("arst_tcnt", q_b, 16'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a, d;
      if ($urandom_range(0, 99) < 45)
        a = {8'hFF, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7))};
      else
        a = 16'($urandom_range(0, 31));
      d = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 49) == 0) sw_in = 10'($urandom);
      cyc(a, d, ($urandom_range(0, 2) == 0));
      if (i == 1500) begin
        #3 resetn = 1'b0;
        @(posedge clock); #1 resetn = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
